// File: rtl/mem_bridge_pkg.sv
// Shared constants for the MEM-stage bus bridge: FSM encodings, bus direction codes and defaults.
package mem_bridge_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic BusRd = 1'b0;
    localparam logic BusWr = 1'b1;

    localparam int unsigned  DefTimeout = 255;
    localparam logic [31:0]  DefErrData = 32'hDEAD_BEEF;

    function automatic logic [31:0] word_to_byte(input logic [29:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/mem_wbuf.sv
// One-entry posted write buffer; capture wins over clear, though the bridge never asserts both.
module mem_wbuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_i,
    input  logic        clear_i,
    input  logic [29:0] cap_addr_i,
    input  logic [31:0] cap_data_i,
    input  logic [29:0] match_addr_i,
    output logic        wb_v_o,
    output logic [29:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        hit_o
);

    logic        v_q, v_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        v_d    = v_q;
        addr_d = addr_q;
        data_d = data_q;
        if (capture_i) begin
            v_d    = 1'b1;
            addr_d = cap_addr_i;
            data_d = cap_data_i;
        end else if (clear_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign wb_v_o    = v_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;
    assign hit_o     = v_q & (addr_q == match_addr_i);

endmodule

// File: rtl/mem_bridge.sv
// Bridges the one-cycle MEM-stage access onto a req/ack bus, stalling the pipeline as needed and
// posting stores through a one-entry write buffer.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DefTimeout,
    parameter logic [31:0] ERR_DATA = DefErrData
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] TimerMax = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        acc, is_store, is_load, load_miss;
    logic        wb_v, hit, capture, clear;
    logic        done, expire;
    logic [29:0] req_addr, wb_addr;
    logic [31:0] wb_data;
    logic        unused_addr;

    assign unused_addr = ^mem_addr[1:0];

    assign acc       = mem_valid & (mem_ren | mem_wen);
    assign is_store  = acc & mem_wen;
    assign is_load   = acc & ~mem_wen;
    assign req_addr  = mem_addr[31:2];
    assign load_miss = is_load & ~hit;
    // A store is only taken when the buffer was empty at the start of the cycle.
    assign capture   = is_store & ~wb_v;
    assign done      = bus_req & bus_ack;
    assign expire    = bus_req & ~bus_ack & (timer_q == TimerMax);
    assign clear     = (state_q == StWrite) & (done | expire);

    mem_wbuf u_wbuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_i    (capture),
        .clear_i      (clear),
        .cap_addr_i   (req_addr),
        .cap_data_i   (mem_dout),
        .match_addr_i (req_addr),
        .wb_v_o       (wb_v),
        .wb_addr_o    (wb_addr),
        .wb_data_o    (wb_data),
        .hit_o        (hit)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        err_d   = err_q | expire;
        unique case (state_q)
            StIdle: begin
                if (wb_v || capture) begin
                    state_d = StWrite;
                    timer_d = '0;
                end else if (load_miss) begin
                    state_d = StRead;
                    timer_d = '0;
                end
            end
            StWrite: begin
                if (done || expire) begin
                    state_d = load_miss ? StRead : StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StRead: begin
                if (done) begin
                    rdata_d = bus_rdata;
                    state_d = StResp;
                end else if (expire) begin
                    rdata_d = ERR_DATA;
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stall is gated by reset so the pipeline is released the instant reset asserts.
    assign mem_stall = rst_n & ((load_miss & (state_q != StResp)) | (is_store & wb_v));
    assign mem_din   = (is_load & hit) ? wb_data : rdata_q;
    assign mem_err   = err_q;

    assign bus_req   = (state_q == StWrite) | (state_q == StRead);
    assign bus_we    = (state_q == StWrite) ? BusWr : BusRd;
    assign bus_addr  = (state_q == StWrite) ? word_to_byte(wb_addr) :
                       (state_q == StRead)  ? word_to_byte(req_addr) : 32'h0;
    assign bus_wdata = (state_q == StWrite) ? wb_data : 32'h0;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: stimulus queues expected bus transfers and load data, a monitor
// pops and compares them as the DUT completes transfers and retires loads.
module tb_mem_bridge;
    import mem_bridge_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [31:0] mem_addr = '0, mem_dout = '0;
    logic [31:0] mem_din;
    logic        mem_stall, mem_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int          n_pass = 0;
    int          n_total = 0;
    int          req_cycles = 0;
    int          req_cnt = 0;
    int          ack_lat = 0;
    logic        no_ack = 1'b0;
    logic        late_ack = 1'b0;
    logic [31:0] rd_val = '0;

    bus_t        exp_bus[$];
    logic [31:0] exp_load[$];

    mem_bridge #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Bus slave: ack after ack_lat wait cycles of the current request.
    always @(posedge clk) begin
        if (!bus_req || bus_ack) req_cnt <= 0;
        else req_cnt <= req_cnt + 1;
    end

    always @(negedge clk) begin
        bus_ack   = late_ack || (bus_req && !no_ack && (req_cnt == ack_lat));
        bus_rdata = rd_val;
    end

    // Monitor
    initial begin
        bus_t e;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus_req) req_cycles++;
                if (bus_req && bus_ack) begin
                    if (exp_bus.size() == 0) begin
                        n_total++;
                        $display("FAIL bus_unexpected: got we=%b addr=%h, required no transfer",
                                 bus_we, bus_addr);
                    end else begin
                        e = exp_bus.pop_front();
                        chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                        chk("bus_addr", bus_addr, e.addr);
                        if (e.we) chk("bus_wdata", bus_wdata, e.data);
                    end
                end
                if (mem_valid && mem_ren && !mem_wen && !mem_stall) begin
                    if (exp_load.size() == 0) begin
                        n_total++;
                        $display("FAIL load_unexpected: got %h, required no load", mem_din);
                    end else begin
                        d = exp_load.pop_front();
                        chk("load_data", mem_din, d);
                    end
                end
            end
        end
    end

    task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] data, output int stalls);
        mem_valid = 1'b1;
        mem_ren   = ren;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_dout  = data;
        stalls    = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #3;
            if (!mem_stall) break;
            stalls++;
        end
        if (mem_stall) begin
            n_total++;
            $display("FAIL issue_timeout: got stall=1, required release within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        mem_valid = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #3;
            if (!bus_req) break;
        end
        if (bus_req) begin
            n_total++;
            $display("FAIL idle_timeout: got bus_req=1, required 0 within 60 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Posted store, then forwarded load while the drain is in flight
        ack_lat = 3;
        exp_bus.push_back('{we: 1'b1, addr: 32'h10, data: 32'hAAAA_5555});
        issue(1'b0, 1'b1, 32'h10, 32'hAAAA_5555, st);
        chk("store_empty_stall", st, 0);
        exp_load.push_back(32'hAAAA_5555);
        mem_ren  = 1'b1;
        mem_wen  = 1'b0;
        mem_addr = 32'h10;
        @(negedge clk);
        #3;
        chk("drain_req", {31'd0, bus_req}, 32'd1);
        chk("drain_we", {31'd0, bus_we}, 32'd1);
        chk("drain_addr", bus_addr, 32'h10);
        chk("fwd_stall", {31'd0, mem_stall}, 32'd0);
        chk("fwd_data", mem_din, 32'hAAAA_5555);
        @(posedge clk);
        #1;
        nop();
        wait_idle();
        chk("wb_empty_after_drain", {31'd0, dut.wb_v}, 32'd0);

        // Load miss with immediate ack
        ack_lat = 0;
        rd_val  = 32'h1234_5678;
        exp_bus.push_back('{we: 1'b0, addr: 32'h20, data: 32'h0});
        exp_load.push_back(32'h1234_5678);
        issue(1'b1, 1'b0, 32'h23, 32'h0, st);
        chk("miss_stall_cycles", st, 2);
        mem_valid = 1'b0;
        @(negedge clk);
        #3;
        chk("idle_after_resp", {30'd0, dut.state_q}, {30'd0, StIdle});
        chk("no_req_after_resp", {31'd0, bus_req}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back stores: second waits for the first drain
        ack_lat = 4;
        exp_bus.push_back('{we: 1'b1, addr: 32'h30, data: 32'h1111_2222});
        exp_bus.push_back('{we: 1'b1, addr: 32'h34, data: 32'h3333_4444});
        issue(1'b0, 1'b1, 32'h30, 32'h1111_2222, st);
        chk("store1_stall", st, 0);
        issue(1'b0, 1'b1, 32'h34, 32'h3333_4444, st);
        chk("store2_stall", st, 5);
        nop();
        wait_idle();

        // Read timeout
        no_ack     = 1'b1;
        req_cycles = 0;
        exp_load.push_back(32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 32'h40, 32'h0, st);
        chk("timeout_stall_cycles", st, 9);
        chk("timeout_req_cycles", req_cycles, 8);
        chk("timeout_err", {31'd0, mem_err}, 32'd1);
        nop();
        chk("err_sticky", {31'd0, mem_err}, 32'd1);

        // Reset in the middle of a read
        mem_valid = 1'b1;
        mem_ren   = 1'b1;
        mem_wen   = 1'b0;
        mem_addr  = 32'h50;
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
        chk("pre_rst_stall", {31'd0, mem_stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus_req}, 32'd0);
        chk("arst_stall", {31'd0, mem_stall}, 32'd0);
        chk("arst_din", mem_din, 32'd0);
        chk("arst_err", {31'd0, mem_err}, 32'd0);
        chk("arst_state", {30'd0, dut.state_q}, {30'd0, StIdle});
        mem_valid = 1'b0;
        mem_ren   = 1'b0;
        @(posedge clk);
        #1;
        no_ack   = 1'b0;
        late_ack = 1'b1;
        rd_val   = 32'hCAFE_F00D;
        rst_n    = 1'b1;
        @(negedge clk);
        #3;
        chk("late_ack_no_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        @(negedge clk);
        #3;
        chk("late_ack_state", {30'd0, dut.state_q}, {30'd0, StIdle});
        chk("late_ack_din", mem_din, 32'd0);

        chk("bus_queue_drained", exp_bus.size(), 0);
        chk("load_queue_drained", exp_load.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
